// File: rtl/ofdm_cp_remove.sv
// Cyclic-prefix remover: drops the CP_LEN prefix of each OFDM symbol and frames the
// N_FFT body samples as one Avalon-ST packet per symbol, tagged with the symbol index.
module ofdm_cp_remove #(
    parameter int unsigned N_FFT  = 64,
    parameter int unsigned CP_LEN = 16
) (
    input  logic        clock_clk,
    input  logic        reset_reset,
    input  logic [31:0] asi_in0_data,
    input  logic        asi_in0_valid,
    input  logic        asi_in0_startofpacket,
    input  logic        asi_in0_endofpacket,
    output logic [31:0] aso_out0_data,
    output logic        aso_out0_valid,
    output logic        aso_out0_startofpacket,
    output logic        aso_out0_endofpacket,
    output logic [7:0]  aso_out0_channel,
    output logic        frame_error
);

    localparam int unsigned MaxLen = (N_FFT > CP_LEN) ? N_FFT : CP_LEN;
    localparam int unsigned CntW   = $clog2(MaxLen) + 1;

    localparam logic [CntW-1:0] CpLast   = CntW'(CP_LEN - 1);
    localparam logic [CntW-1:0] BodyLast = CntW'(N_FFT - 1);

    typedef enum logic [1:0] {StIdle, StCp, StBody} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      sym_q, sym_d;
    logic [31:0]     data_q, data_d;
    logic [7:0]      chan_q, chan_d;
    logic            vld_q, vld_d;
    logic            sop_q, sop_d;
    logic            eop_q, eop_d;
    logic            err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sym_d   = sym_q;
        data_d  = data_q;
        chan_d  = chan_q;
        vld_d   = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        err_d   = 1'b0;

        if (asi_in0_valid) begin
            // A SOP sample (from any state) is CP sample 0 of a fresh burst; a SOP+EOP
            // sample can never start a burst and collapses to an error back in idle.
            if (asi_in0_startofpacket) begin
                err_d = (state_q != StIdle) || asi_in0_endofpacket;
                sym_d = 8'd0;
                if (asi_in0_endofpacket) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (CP_LEN == 1) begin
                    state_d = StBody;
                    cnt_d   = '0;
                end else begin
                    state_d = StCp;
                    cnt_d   = CntW'(1);
                end
            end else begin
                case (state_q)
                    StCp: begin
                        if (asi_in0_endofpacket) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                            cnt_d   = '0;
                            sym_d   = 8'd0;
                        end else if (cnt_q == CpLast) begin
                            state_d = StBody;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                    StBody: begin
                        vld_d  = 1'b1;
                        data_d = asi_in0_data;
                        chan_d = sym_q;
                        sop_d  = (cnt_q == '0);
                        eop_d  = (cnt_q == BodyLast) || asi_in0_endofpacket;
                        if (asi_in0_endofpacket) begin
                            err_d   = (cnt_q != BodyLast);
                            state_d = StIdle;
                            cnt_d   = '0;
                            sym_d   = 8'd0;
                        end else if (cnt_q == BodyLast) begin
                            state_d = StCp;
                            cnt_d   = '0;
                            sym_d   = sym_q + 8'd1;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sym_q   <= 8'd0;
            data_q  <= 32'd0;
            chan_q  <= 8'd0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            err_q   <= err_d;
        end
    end

    assign aso_out0_data          = data_q;
    assign aso_out0_valid         = vld_q;
    assign aso_out0_startofpacket = sop_q;
    assign aso_out0_endofpacket   = eop_q;
    assign aso_out0_channel       = chan_q;
    assign frame_error            = err_q;

endmodule
